// File: rtl/fetch_sequencer.sv
// Fetch PC owner: sequential/redirect/trap arbitration, single-outstanding
// instruction-ROM handshake and a one-entry valid/ready buffer toward decode.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_vector,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] fetch_next_pc,
  output logic [31:0]       fetch_instr,
  output logic [15:0]       redirect_count
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DISCARD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] buf_pc;
  logic [31:0]       buf_instr;
  logic [15:0]       count;
  logic              redir;
  logic [ADDR_W-1:0] target;

  // Trap wins over EX redirect; targets are always word aligned.
  assign redir  = (state != IDLE) && (trap_valid || redirect_valid);
  assign target = (trap_valid ? trap_vector : redirect_target) & ~ADDR_W'(3);

  assign imem_req       = (state == REQ);
  assign imem_addr      = pc;
  assign fetch_valid    = (state == HOLD);
  assign fetch_pc       = buf_pc;
  assign fetch_next_pc  = buf_pc + ADDR_W'(4);
  assign fetch_instr    = buf_instr;
  assign redirect_count = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_VECTOR;
      buf_pc    <= '0;
      buf_instr <= '0;
      count     <= '0;
    end else begin
      if (redir && (count != '1)) begin
        count <= count + 16'd1;
      end

      unique case (state)
        IDLE: state <= REQ;

        REQ: begin
          if (redir) begin
            pc <= target;
            if (imem_gnt) state <= DISCARD;
          end else if (imem_gnt) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redir) begin
            pc    <= target;
            state <= imem_rvalid ? REQ : DISCARD;
          end else if (imem_rvalid) begin
            buf_pc    <= pc;
            buf_instr <= imem_rdata;
            pc        <= pc + ADDR_W'(4);
            state     <= HOLD;
          end
        end

        // Waiting out a cancelled response; later redirects just retarget pc.
        DISCARD: begin
          if (redir) pc <= target;
          if (imem_rvalid) state <= REQ;
        end

        HOLD: begin
          if (redir) begin
            pc    <= target;
            state <= REQ;
          end else if (fetch_ready) begin
            state <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, compared against a flag-based transaction model.
module tb_fetch_sequencer;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          trap_valid = 1'b0;
  logic [AW-1:0] trap_vector = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          fetch_valid;
  logic          fetch_ready = 1'b0;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] fetch_next_pc;
  logic [31:0]   fetch_instr;
  logic [15:0]   redirect_count;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W      (AW),
    .RESET_VECTOR('0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_next_pc  (fetch_next_pc),
    .fetch_instr    (fetch_instr),
    .redirect_count (redirect_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: what is in flight, expressed as independent flags.
  logic        m_started, m_presenting, m_outstanding, m_stale, m_buf_valid;
  logic [31:0] m_pc, m_buf_pc, m_buf_instr;
  int unsigned m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_presenting = 0; m_outstanding = 0; m_stale = 0; m_buf_valid = 0;
    m_pc = 32'h0; m_buf_pc = 32'h0; m_buf_instr = 32'h0; m_count = 0;
  endtask

  task automatic model_cycle();
    logic        acc;
    logic [31:0] tgt;
    acc = m_started && (trap_valid || redirect_valid);
    tgt = trap_valid ? trap_vector : redirect_target;
    tgt[1:0] = 2'b00;
    if (!m_started) begin
      m_started = 1; m_presenting = 1;
    end else begin
      if (acc && m_count < 65535) m_count++;
      if (m_presenting) begin
        if (imem_gnt) begin
          m_presenting = 0; m_outstanding = 1; m_stale = acc;
        end
        if (acc) m_pc = tgt;
      end else if (m_outstanding) begin
        if (imem_rvalid) begin
          m_outstanding = 0;
          if (m_stale || acc) m_presenting = 1;
          else begin
            m_buf_valid = 1; m_buf_pc = m_pc; m_buf_instr = imem_rdata; m_pc = m_pc + 32'd4;
          end
        end else if (acc) m_stale = 1;
        if (acc) m_pc = tgt;
      end else if (m_buf_valid) begin
        if (acc || fetch_ready) begin
          m_buf_valid = 0; m_presenting = 1;
        end
        if (acc) m_pc = tgt;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req", imem_req, m_presenting);
    check("imem_addr", imem_addr, m_pc);
    check("fetch_valid", fetch_valid, m_buf_valid);
    check("redirect_count", redirect_count, m_count);
    if (m_buf_valid) begin
      check("fetch_pc", fetch_pc, m_buf_pc);
      check("fetch_next_pc", fetch_next_pc, m_buf_pc + 32'd4);
      check("fetch_instr", fetch_instr, m_buf_instr);
    end
  endtask

  task automatic step(input logic tv, input logic [31:0] tvec, input logic rv,
                      input logic [31:0] rt, input logic g, input logic rvl,
                      input logic [31:0] rd, input logic rdy);
    trap_valid = tv; trap_vector = tvec; redirect_valid = rv; redirect_target = rt;
    imem_gnt = g; imem_rvalid = rvl; imem_rdata = rd; fetch_ready = rdy;
    @(posedge clk);
    model_cycle();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 0;
    trap_valid = 0; redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0; fetch_ready = 0;
    #1;
    model_reset();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_fetch_valid", fetch_valid, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_count", redirect_count, 16'h0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_fetch_instr", fetch_instr, 32'h0);
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1;
  endtask

  initial begin
    do_reset();

    // Best case: gnt/rvalid always high, decode always ready.
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0, 1, 1, 32'hA000_0000 | i, 1);
      if (i % 3 == 0) begin
        check("bc_valid", fetch_valid, 1'b1);
        check("bc_pc", fetch_pc, 32'((i / 3 - 1) * 4));
        check("bc_next_pc", fetch_next_pc, 32'((i / 3) * 4));
      end else begin
        check("bc_not_valid", fetch_valid, 1'b0);
      end
    end

    // Decode stalls for five cycles while holding pc 8.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 1, $urandom(), 0);
      check("stall_valid", fetch_valid, 1'b1);
      check("stall_pc", fetch_pc, 32'h8);
      check("stall_instr", fetch_instr, 32'hA000_0009);
      check("stall_req", imem_req, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0, $urandom(), 1);
    check("resume_addr", imem_addr, 32'hC);
    check("resume_req", imem_req, 1'b1);

    // Redirect in WAIT, late response is dropped.
    do_reset();
    step(0, 0, 0, 0, 1, 0, $urandom(), 1);
    step(0, 0, 0, 0, 1, 0, $urandom(), 1);
    step(0, 0, 1, 32'h40, 0, 0, $urandom(), 1);
    check("wr_valid0", fetch_valid, 1'b0);
    step(0, 0, 0, 0, 0, 0, $urandom(), 1);
    step(0, 0, 0, 0, 0, 0, $urandom(), 1);
    step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    check("wr_valid1", fetch_valid, 1'b0);
    check("wr_addr", imem_addr, 32'h40);
    check("wr_req", imem_req, 1'b1);
    check("wr_count", redirect_count, 16'd1);

    // Trap and redirect together in REQ: trap wins, single count.
    do_reset();
    step(0, 0, 0, 0, 0, 0, $urandom(), 1);
    step(1, 32'h100, 1, 32'h40, 0, 0, $urandom(), 1);
    check("tr_addr", imem_addr, 32'h100);
    check("tr_count", redirect_count, 16'd1);

    // PC wrap and target alignment.
    do_reset();
    step(0, 0, 0, 0, 0, 0, $urandom(), 1);
    step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, $urandom(), 0);
    step(0, 0, 0, 0, 1, 0, $urandom(), 0);
    step(0, 0, 0, 0, 0, 1, 32'h1234_5678, 0);
    check("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
    check("wrap_next_pc", fetch_next_pc, 32'h0);
    step(0, 0, 0, 0, 0, 0, $urandom(), 1);
    check("wrap_addr", imem_addr, 32'h0);
    step(0, 0, 1, 32'h43, 0, 0, $urandom(), 1);
    check("align_addr", imem_addr, 32'h40);
    check("align_count", redirect_count, 16'd2);

    // Reset mid-WAIT, stale response after release is ignored.
    do_reset();
    step(0, 0, 1, 32'h80, 0, 0, $urandom(), 1);
    step(0, 0, 0, 0, 1, 0, $urandom(), 1);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    check("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_valid", fetch_valid, 1'b0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_count", redirect_count, 16'h0);
    imem_gnt = 0; imem_rvalid = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    step(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0, 1);
    step(0, 0, 0, 0, 0, 1, 32'hBAD1_BAD1, 1);
    check("post_rst_req", imem_req, 1'b1);
    check("post_rst_addr", imem_addr, 32'h0);
    step(0, 0, 0, 0, 1, 0, $urandom(), 1);
    step(0, 0, 0, 0, 0, 1, 32'h0000_0013, 1);
    check("post_rst_pc", fetch_pc, 32'h0);
    check("post_rst_instr", fetch_instr, 32'h0000_0013);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(15) == 0), $urandom(), ($urandom_range(7) == 0), $urandom(),
           $urandom_range(1), $urandom_range(1), $urandom(), ($urandom_range(9) < 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the architectural fetch PC and sequences instruction-memory reads for the front end. Arbitrates between sequential fetch, taken-branch/jump redirects from EX and trap redirects, and runs a single-outstanding request/grant/response handshake to instruction ROM. Delivers one instruction at a time to decode through a one-entry valid/ready output buffer. Responses belonging to a fetch that a redirect has cancelled are discarded.

## Interface
- ADDR_W, 32, width of ROM byte addresses (RomAddress).
- RESET_VECTOR, 0, PC loaded on reset.

- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trap_valid  in  1  trap redirect request; highest priority.
- trap_vector  in  ADDR_W  trap target.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_target  in  ADDR_W  branch target (current_pc + offset, computed by EX).
- imem_req  out  1  read request.
- imem_addr  out  ADDR_W  request address; equals internal pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- fetch_valid  out  1  buffered instruction available.
- fetch_ready  in  1  decode accepts instruction.
- fetch_pc  out  ADDR_W  address of buffered instruction.
- fetch_next_pc  out  ADDR_W  fetch_pc + 4 (JAL/JALR link value).
- fetch_instr  out  32  buffered instruction.
- redirect_count  out  16  accepted trap+redirect events, saturating.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DISCARD. Registers: pc, buf_pc, buf_instr, redirect_count.
- imem_req = (state == REQ); imem_addr = pc; fetch_valid = (state == HOLD); fetch_pc = buf_pc.
- Redirect source: trap_valid ? trap_vector : redirect_target, accepted when trap_valid | redirect_valid, in any state except IDLE. Bits [1:0] of target forced to 0. Each accepted event increments redirect_count (saturates at 0xFFFF).
- IDLE -> REQ unconditionally.
- REQ, no redirect: gnt=0 stay; gnt=1 -> WAIT.
- REQ, redirect: gnt=0 -> pc=target, stay REQ (address may change before grant); gnt=1 -> pc=target, DISCARD.
- WAIT, no redirect: rvalid=1 -> buf_pc=pc, buf_instr=rdata, pc=pc+4, HOLD; else stay.
- WAIT, redirect: pc=target; rvalid=1 -> data dropped, REQ; rvalid=0 -> DISCARD.
- DISCARD: rvalid=1 -> data dropped, REQ; further redirects update pc and remain in DISCARD.
- HOLD: redirect -> pc=target, REQ (buffer dropped; if fetch_ready same cycle, handshake still counts as completed); fetch_ready=1 -> REQ at pc; else stay.
- Arithmetic: pc + 4 and fetch_next_pc wrap modulo 2^ADDR_W.
- imem_rvalid outside WAIT/DISCARD is a protocol violation; ignored.

## Timing
- Reset asserted (async): state=IDLE, pc=RESET_VECTOR, imem_req=0, fetch_valid=0, buf_pc=0, buf_instr=0, redirect_count=0. Reset mid-transaction abandons any outstanding request; a late rvalid after release is ignored because state is IDLE/REQ.
- First imem_req: first rising edge after release enters REQ; imem_req high in cycle 1.
- Best-case latency, gnt and rvalid each 1 cycle after entry: REQ (c1) -> WAIT (c2) -> HOLD (c3, fetch_valid=1) -> REQ (c4, if ready in c3). Peak throughput 1 instruction / 3 cycles.
- Redirect asserted in cycle n: imem_addr shows target in cycle n+1 (REQ) unless DISCARD is pending; fetch_valid low in n+1.
- All outputs are register- or state-decoded; no input-to-output combinational path.

## Test plan
- Reset release, gnt/rvalid immediate, ready=1: fetch_pc sequence 0,4,8 on fetch_valid cycles 3,6,9; fetch_next_pc 4,8,12.
- fetch_ready low 5 cycles in HOLD: fetch_valid, fetch_pc, fetch_instr stable; imem_req stays 0; resume at next pc after ready.
- Redirect to 0x40 in WAIT with rvalid 3 cycles later: response dropped (fetch_valid never shows it), next imem_addr 0x40, redirect_count=1.
- trap_valid (0x100) and redirect_valid (0x40) same cycle in REQ with gnt=0: imem_addr=0x100 next cycle, count increments once.
- pc=0xFFFFFFFC fetched: next imem_addr 0x0; target 0x43 -> imem_addr 0x40.
- reset_n pulsed low mid-WAIT: outputs reset immediately, stale rvalid ignored, refetch from RESET_VECTOR.
